// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM encoding,
// default start address and the word shown on iin before anything is fetched.
package pkg_busca;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT         = 2'd1,
        WAIT_DISCARD = 2'd2
    } estado_t;

    localparam logic [7:0]  RESET_PC_DEF = 8'h00;
    localparam logic [15:0] NOP          = 16'h0000;

endpackage

// File: rtl/unidade_busca_fifo.sv
// Prefetch buffer: synchronous FIFO of {instruction, address} entries.
// Storage is plain registers; flush empties it in one cycle.
module fifo_busca #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

    a_no_overflow:  assert property (@(posedge clk) disable iff (srst) !(push && !pop && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (srst) !(pop && empty));

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: owns the PC, fetches over a single-outstanding req/ack
// port into a prefetch FIFO and holds one instruction on iin until instr_done.
module unidade_busca
    import pkg_busca::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 16,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_value,
    input  logic              instr_done,
    output logic [DATA_W-1:0] iin,
    output logic              iin_valid,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    estado_t           state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] iin_reg, iin_next;
    logic              iin_valid_reg, iin_valid_next;
    logic [ADDR_W-1:0] pc_out_reg, pc_out_next;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               room_after_push;

    fifo_busca #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (pc_load),
        .wr_data ({mem_data, mem_addr_reg}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The instruction register takes the head when it is free or being retired;
    // a redirect overrides both.
    assign fifo_pop        = !fifo_empty && (!iin_valid_reg || instr_done) && !pc_load;
    assign room_after_push = fifo_pop || (fifo_count < CNT_W'(FIFO_DEPTH - 1));

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        fifo_push     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pc_load) begin
                    pc_next = pc_value;
                end else if (!fifo_full) begin
                    state_next    = WAIT;
                    mem_req_next  = 1'b1;
                    mem_addr_next = pc_reg;
                end
            end

            WAIT: begin
                if (pc_load) begin
                    pc_next = pc_value;
                    if (mem_ack) begin
                        state_next   = IDLE;
                        mem_req_next = 1'b0;
                    end else begin
                        state_next = WAIT_DISCARD;
                    end
                end else if (mem_ack) begin
                    fifo_push = 1'b1;
                    pc_next   = pc_reg + ADDR_W'(1);
                    if (room_after_push) begin
                        mem_addr_next = pc_reg + ADDR_W'(1);
                    end else begin
                        state_next   = IDLE;
                        mem_req_next = 1'b0;
                    end
                end
            end

            WAIT_DISCARD: begin
                // The PC already points at the redirect target; only the
                // in-flight word has to be swallowed.
                if (pc_load) begin
                    pc_next = pc_value;
                end
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                end
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        iin_next       = iin_reg;
        iin_valid_next = iin_valid_reg;
        pc_out_next    = pc_out_reg;

        if (pc_load) begin
            iin_valid_next = 1'b0;
        end else if (fifo_pop) begin
            iin_next       = fifo_head[ENTRY_W-1:ADDR_W];
            pc_out_next    = fifo_head[ADDR_W-1:0];
            iin_valid_next = 1'b1;
        end else if (instr_done && iin_valid_reg) begin
            iin_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= RESET_PC;
            iin_reg       <= DATA_W'(NOP);
            iin_valid_reg <= 1'b0;
            pc_out_reg    <= RESET_PC;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            iin_reg       <= iin_next;
            iin_valid_reg <= iin_valid_next;
            pc_out_reg    <= pc_out_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign iin       = iin_reg;
    assign iin_valid = iin_valid_reg;
    assign pc_out    = pc_out_reg;

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
- Instruction fetch stage directly upstream of the processor; drives its 16-bit `iin` input.
- Owns the program counter and issues single-outstanding read requests to program memory over a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO and presents one instruction word, held stable, until the processor signals completion via `instr_done`.
- Supports PC redirect with flush.

Parameters:
- ADDR_W, 8, program-memory address width (PC width).
- DATA_W, 16, instruction word width; matches processor `iin`.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, >= 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  read request to program memory.
- mem_addr  output  ADDR_W  read address, valid while mem_req=1.
- mem_ack  input  1  memory response strobe; mem_data valid this cycle.
- mem_data  input  DATA_W  instruction word returned by memory.
- pc_load  input  1  redirect request (jump).
- pc_value  input  ADDR_W  redirect target.
- instr_done  input  1  processor finished the current instruction (step counter cleared).
- iin  output  DATA_W  current instruction to processor.
- iin_valid  output  1  iin holds a valid instruction.
- pc_out  output  ADDR_W  address of the instruction currently on iin.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset values:
  - pc = RESET_PC; mem_req = 0; mem_addr = RESET_PC.
  - FIFO empty; iin = 16'h0000; iin_valid = 0; pc_out = RESET_PC; state = IDLE.
- Fetch FSM states: IDLE, WAIT, WAIT_DISCARD.
- IDLE -> WAIT when (FIFO count + 0 outstanding) < FIFO_DEPTH and pc_load = 0:
  - mem_req = 1, mem_addr = pc, registered.
- WAIT:
  - mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack: push {mem_data, mem_addr} into the FIFO, pc <= pc + 1, return to IDLE.
  - May re-issue in the same cycle (WAIT -> WAIT) if space remains after the push.
- Request protocol: at most one outstanding request. A request is never withdrawn before ack.
- PC arithmetic is modulo 2^ADDR_W; 8'hFF + 1 wraps to 8'h00 silently.
- Instruction register (iin/pc_out):
  - Loads the FIFO head when iin_valid = 0, or when instr_done = 1, and the FIFO is non-empty; pops that entry.
  - A word pushed on cycle N is visible on iin no earlier than cycle N+1 (FIFO registered, no bypass).
  - instr_done with FIFO empty: iin_valid <= 0 and iin holds its last value.
  - instr_done while iin_valid = 0 is ignored.
- Redirect on pc_load = 1:
  - pc <= pc_value; FIFO flushed; iin_valid <= 0 next cycle.
  - Occurring in WAIT without mem_ack: state -> WAIT_DISCARD (mem_req stays high, address unchanged).
  - In WAIT with mem_ack in the same cycle: the returned data is dropped, pc <= pc_value, state -> IDLE.
- WAIT_DISCARD: on mem_ack, data dropped, pc unchanged (already redirected), -> IDLE. A further pc_load here just updates pc.
- Simultaneous events:
  - pc_load has priority over instr_done and over FIFO pushes.
  - A push and a pop in the same cycle with the FIFO full is legal; count unchanged.
- Reset mid-transaction:
  - All state cleared; mem_req drops the following cycle.
  - A late mem_ack arriving after reset is ignored (state IDLE).
- Occupancy bound: FIFO never overflows by construction; overflow assertion provided for verification.

Decomposition:
- Shared package `pkg_busca`: FSM state encoding (IDLE=2'd0, WAIT=2'd1, WAIT_DISCARD=2'd2), RESET_PC default, NOP constant 16'h0000.
- One sub-module `fifo_busca`:
  - Synchronous FIFO, DATA_W+ADDR_W wide, FIFO_DEPTH deep.
  - Ports: push, pop, flush, full, empty, count.
- The FSM and PC live in `unidade_busca`.

Test Plan:
- Reset, then zero-latency memory returning addr+16'h1000 -> mem_addr 0,1,2...; iin = 16'h1000 with iin_valid = 1 by cycle 3; pc_out = 0.
- Memory latency 3 cycles, instr_done pulsed every cycle -> iin sequence 16'h1000, 16'h1001, ... with iin_valid gaps; mem_req never drops before ack; never two outstanding.
- instr_done withheld 10 cycles -> FIFO fills to 2; mem_req deasserts; iin stable at 16'h1000.
- pc_load = 1, pc_value = 8'h40 while in WAIT with latency 2 -> stale ack data dropped; next iin = 16'h1040, pc_out = 8'h40.
- RESET_PC = 8'hFE, continuous fetch -> addresses FE, FF, 00, 01; pc_out wraps identically.
- reset asserted during WAIT -> next cycle mem_req = 0, iin_valid = 0; ack 1 cycle later ignored; fetch restarts at RESET_PC.
